// File: rtl/d_store_split_pkg.sv
// Shared types and constants for the store splitter: size codes, FSM states,
// beat geometry and the byte-mask helper.
package d_store_split_pkg;

  localparam int BEAT_BYTES = 8;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_W = 2'b01,
    SZ_D = 2'b10,
    SZ_Q = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOW  = 2'b01,
    ST_HIGH = 2'b10
  } state_e;

  // Contiguous low-order byte mask covering 1, 2, 4 or 8 bytes.
  function automatic logic [BEAT_BYTES-1:0] size_mask(input size_e size);
    logic [BEAT_BYTES-1:0] mask;
    case (size)
      SZ_B:    mask = 8'h01;
      SZ_W:    mask = 8'h03;
      SZ_D:    mask = 8'h0F;
      default: mask = 8'hFF;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/d_store_shift.sv
// Combinational write-side byte shifter: places right-justified store data and
// its byte mask at the byte offset, spilling into a second 8-byte word.
module d_store_shift
  import d_store_split_pkg::*;
(
  input  logic [63:0]           data,
  input  logic [BEAT_BYTES-1:0] mask,
  input  logic [2:0]            off,
  output logic [127:0]          shifted,
  output logic [15:0]           enables
);

  assign shifted = {64'b0, data} << {off, 3'b000};
  assign enables = {8'b0, mask} << off;

endmodule

// File: rtl/d_store_split.sv
// Splits an arbitrary-alignment store of 1..8 bytes into one or two
// 8-byte-aligned write beats with byte enables.
module d_store_split
  import d_store_split_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_data,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [63:0] mem_data,
  output logic [7:0]  mem_be,
  output logic        done
);

  state_e      state, state_nxt;
  logic [31:0] addr_q;
  size_e       size_q;
  logic [63:0] data_q;

  logic [127:0] shifted;
  logic [15:0]  enables;
  logic [31:0]  base_addr;
  logic         has_high;

  d_store_shift u_shift (
    .data    (data_q),
    .mask    (size_mask(size_q)),
    .off     (addr_q[2:0]),
    .shifted (shifted),
    .enables (enables)
  );

  assign base_addr = {addr_q[31:3], 3'b000};
  assign has_high  = |enables[15:8];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      // NOTE: the request registers are cleared on reset too, so the beat
      // outputs never expose stale store data after a restart.
      addr_q <= '0;
      size_q <= SZ_B;
      data_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE && req_valid) begin
        addr_q <= req_addr;
        size_q <= size_e'(req_size);
        data_q <= req_data;
      end
    end
  end

  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;
    mem_be    = '0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = ST_LOW;
      end
      ST_LOW: begin
        mem_valid = 1'b1;
        mem_addr  = base_addr;
        mem_data  = shifted[63:0];
        mem_be    = enables[7:0];
        if (mem_ready) begin
          state_nxt = has_high ? ST_HIGH : ST_IDLE;
          done      = !has_high && reset;
        end
      end
      ST_HIGH: begin
        mem_valid = 1'b1;
        mem_addr  = base_addr + 32'd8;  // wraps 0xFFFFFFF8 -> 0x00000000
        mem_data  = shifted[127:64];
        mem_be    = enables[15:8];
        if (mem_ready) begin
          state_nxt = ST_IDLE;
          done      = reset;  // an aborting reset suppresses completion
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_d_store_split.sv
// Directed self-checking bench for d_store_split: aligned, split, wrapping,
// stalled and reset-aborted stores with hand-computed beats.
module tb_d_store_split;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic [63:0] req_data;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [63:0] mem_data;
  logic [7:0]  mem_be;
  logic        done;

  int n_checks = 0;
  int n_err    = 0;
  int beats    = 0;
  int b0;

  always #5 clk = ~clk;

  d_store_split dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_size  (req_size),
    .req_data  (req_data),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_be    (mem_be),
    .done      (done)
  );

  // Accepted beats outside reset
  always @(posedge clk)
    if (reset && mem_valid && mem_ready) beats <= beats + 1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_beat(input string tag, input logic [31:0] a, input logic [63:0] d,
                            input logic [7:0] be, input logic dn);
    #1;
    check({tag, ".valid"}, 128'(mem_valid), 128'(1'b1));
    check({tag, ".addr"},  128'(mem_addr),  128'(a));
    check({tag, ".data"},  128'(mem_data),  128'(d));
    check({tag, ".be"},    128'(mem_be),    128'(be));
    check({tag, ".done"},  128'(done),      128'(dn));
    check({tag, ".rdy"},   128'(req_ready), 128'(1'b0));
  endtask

  task automatic check_idle(input string tag);
    #1;
    check({tag, ".valid"}, 128'(mem_valid), 128'(1'b0));
    check({tag, ".done"},  128'(done),      128'(1'b0));
    check({tag, ".rdy"},   128'(req_ready), 128'(1'b1));
  endtask

  task automatic issue(input logic [31:0] a, input logic [1:0] s, input logic [63:0] d);
    req_valid = 1'b1;
    req_addr  = a;
    req_size  = s;
    req_data  = d;
    tick();
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;
    req_data  = 64'hFFFF_FFFF_FFFF_FFFF;
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_addr  = '0;
    req_size  = '0;
    req_data  = '0;
    mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    check_idle("reset");

    // Aligned doubleword: single beat, done with it
    b0 = beats;
    mem_ready = 1'b1;
    issue(32'h0000_1000, 2'b11, 64'h8877_6655_4433_2211);
    check_beat("dw", 32'h0000_1000, 64'h8877_6655_4433_2211, 8'hFF, 1'b1);
    tick();
    check_idle("dw_end");
    check("dw.beats", 128'(beats - b0), 128'(1));

    // Word at offset 5 splits across two beats
    b0 = beats;
    issue(32'h0000_1005, 2'b10, 64'h4433_2211);
    check_beat("split1", 32'h0000_1000, 64'h3322_1100_0000_0000, 8'hE0, 1'b0);
    tick();
    check_beat("split2", 32'h0000_1008, 64'h44, 8'h01, 1'b1);
    tick();
    check_idle("split_end");
    check("split.beats", 128'(beats - b0), 128'(2));

    // Halfword at top of address space wraps the second beat to 0
    b0 = beats;
    issue(32'hFFFF_FFFF, 2'b01, 64'hBBAA);
    check_beat("wrap1", 32'hFFFF_FFF8, 64'hAA00_0000_0000_0000, 8'h80, 1'b0);
    tick();
    check_beat("wrap2", 32'h0000_0000, 64'hBB, 8'h01, 1'b1);
    tick();
    check_idle("wrap_end");
    check("wrap.beats", 128'(beats - b0), 128'(2));

    // Split store with 3 stall cycles per beat; a pending request must wait
    b0 = beats;
    mem_ready = 1'b0;
    issue(32'h0000_1005, 2'b10, 64'h4433_2211);
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_beat("stall1", 32'h0000_1000, 64'h3322_1100_0000_0000, 8'hE0, 1'b0);
      tick();
    end
    mem_ready = 1'b1;
    check_beat("stall1go", 32'h0000_1000, 64'h3322_1100_0000_0000, 8'hE0, 1'b0);
    tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_beat("stall2", 32'h0000_1008, 64'h44, 8'h01, 1'b0);
      tick();
    end
    mem_ready = 1'b1;
    req_valid = 1'b0;
    check_beat("stall2go", 32'h0000_1008, 64'h44, 8'h01, 1'b1);
    tick();
    check_idle("stall_end");
    check("stall.beats", 128'(beats - b0), 128'(2));

    // Reset while the high beat is pending aborts the store
    b0 = beats;
    issue(32'h0000_1005, 2'b10, 64'h4433_2211);
    check_beat("abort1", 32'h0000_1000, 64'h3322_1100_0000_0000, 8'hE0, 1'b0);
    tick();
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    check("abort.done_in_rst", 128'(done), 128'(1'b0));
    tick();
    reset = 1'b1;
    mem_ready = 1'b1;
    check_idle("abort_after");
    tick();
    check_idle("abort_later");
    check("abort.beats", 128'(beats - b0), 128'(1));

    // Reset coinciding with a final-beat memory transfer suppresses done
    b0 = beats;
    issue(32'h0000_1000, 2'b11, 64'h0123_4567_89AB_CDEF);
    reset = 1'b0;
    #1;
    check("rst_xfer.done", 128'(done), 128'(1'b0));
    tick();
    reset = 1'b1;
    check_idle("rst_xfer_after");
    check("rst_xfer.beats", 128'(beats - b0), 128'(0));

    // Byte store at offset 3
    b0 = beats;
    issue(32'h0000_2003, 2'b00, 64'h5A);
    check_beat("byte", 32'h0000_2000, 64'h5A00_0000, 8'h08, 1'b1);
    tick();
    check_idle("byte_end");
    check("byte.beats", 128'(beats - b0), 128'(1));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
